// File: rtl/kamacore_pkg.sv
// kamacore shared types and widths for the writeback slice.
// Load sizes and FSM states used by kamacore_writeback.
package kamacore_pkg;

    localparam int CPU_WIDTH      = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        LOAD_BYTE = 2'd0,
        LOAD_HALF = 2'd1,
        LOAD_WORD = 2'd2
    } load_size_t;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/kamacore_load_extract.sv
// kamacore load extraction: picks byte/half/word from the read word
// by byte offset and sign- or zero-extends it to CPU_WIDTH.
module kamacore_load_extract
    import kamacore_pkg::*;
(
    input  load_size_t             size,
    input  logic                   is_signed,
    input  logic [1:0]             byte_off,
    input  logic [CPU_WIDTH-1:0]   rdata,
    output logic [CPU_WIDTH-1:0]   data
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    // halfword lanes only use the upper offset bit
    assign sel_b = rdata[8*byte_off +: 8];
    assign sel_h = rdata[16*byte_off[1] +: 16];

    // size decode with sign/zero extension
    always_comb begin
        data = rdata;
        unique case (size)
            LOAD_BYTE: data = {{(CPU_WIDTH-8){is_signed & sel_b[7]}}, sel_b};
            LOAD_HALF: data = {{(CPU_WIDTH-16){is_signed & sel_h[15]}}, sel_h};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/kamacore_writeback.sv
// kamacore writeback stage: ALU results and load responses to the regfile.
// Subword load extraction is enabled by `define KAMACORE_SUBWORD_LOAD_EN.
module kamacore_writeback
    import kamacore_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = 255
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic [CPU_WIDTH-1:0]      ex_data,
    input  logic                      ex_is_load,
    input  load_size_t                ex_load_size,
    input  logic                      ex_load_signed,
    input  logic [1:0]                ex_byte_off,
    input  logic                      mem_rvalid,
    input  logic [CPU_WIDTH-1:0]      mem_rdata,
    output logic                      destination_we,
    output logic [REG_ADDR_WIDTH-1:0] destination_a,
    output logic [CPU_WIDTH-1:0]      destination_data,
    output logic                      busy,
    output logic                      load_timeout
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(LOAD_TIMEOUT);

    wb_state_t                 state_q, state_d;
    logic [15:0]               cnt_q, cnt_d, cnt_inc;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      we_q, we_d;
    logic [REG_ADDR_WIDTH-1:0] a_q, a_d;
    logic [CPU_WIDTH-1:0]      data_q, data_d;
    logic                      to_q, to_d;
    logic [CPU_WIDTH-1:0]      load_val;

`ifdef KAMACORE_SUBWORD_LOAD_EN
    load_size_t size_q, size_d;
    logic       sgn_q, sgn_d;
    logic [1:0] off_q, off_d;

    kamacore_load_extract u_extract (
        .size      (size_q),
        .is_signed (sgn_q),
        .byte_off  (off_q),
        .rdata     (mem_rdata),
        .data      (load_val)
    );
`else
    logic unused_load_cfg;

    // full word passes straight through; descriptor fields are don't-care
    assign load_val        = mem_rdata;
    assign unused_load_cfg = ^{ex_load_size, ex_load_signed, ex_byte_off};
`endif

    assign cnt_inc = cnt_q + 16'd1;

    // next-state: accept in IDLE, wait for response or abort on timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        we_d    = 1'b0;
        a_d     = a_q;
        data_d  = data_q;
        to_d    = 1'b0;
`ifdef KAMACORE_SUBWORD_LOAD_EN
        size_d  = size_q;
        sgn_d   = sgn_q;
        off_d   = off_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_is_load) begin
                        state_d = WAIT_LOAD;
                        cnt_d   = 16'd0;
                        rd_d    = ex_rd;
`ifdef KAMACORE_SUBWORD_LOAD_EN
                        size_d  = ex_load_size;
                        sgn_d   = ex_load_signed;
                        off_d   = ex_byte_off;
`endif
                    end else begin
                        we_d   = (ex_rd != '0);
                        a_d    = ex_rd;
                        data_d = ex_data;
                    end
                end
            end
            WAIT_LOAD: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                    we_d    = (rd_q != '0);
                    a_d     = rd_q;
                    data_d  = load_val;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            a_q     <= '0;
            data_q  <= '0;
            to_q    <= 1'b0;
`ifdef KAMACORE_SUBWORD_LOAD_EN
            size_q  <= LOAD_WORD;
            sgn_q   <= 1'b0;
            off_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            a_q     <= a_d;
            data_q  <= data_d;
            to_q    <= to_d;
`ifdef KAMACORE_SUBWORD_LOAD_EN
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            off_q   <= off_d;
`endif
        end
    end

    assign ex_ready         = (state_q == IDLE);
    assign busy             = (state_q == WAIT_LOAD);
    assign destination_we   = we_q;
    assign destination_a    = a_q;
    assign destination_data = data_q;
    assign load_timeout     = to_q;

endmodule

// File: tb/tb_kamacore_writeback.sv
// Directed bench for kamacore_writeback (LOAD_TIMEOUT = 4).
// Expected load data follows KAMACORE_SUBWORD_LOAD_EN when defined.
module tb_kamacore_writeback;
    import kamacore_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      ex_valid;
    logic                      ex_ready;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic [CPU_WIDTH-1:0]      ex_data;
    logic                      ex_is_load;
    load_size_t                ex_load_size;
    logic                      ex_load_signed;
    logic [1:0]                ex_byte_off;
    logic                      mem_rvalid;
    logic [CPU_WIDTH-1:0]      mem_rdata;
    logic                      destination_we;
    logic [REG_ADDR_WIDTH-1:0] destination_a;
    logic [CPU_WIDTH-1:0]      destination_data;
    logic                      busy;
    logic                      load_timeout;

    int total = 0;
    int bad   = 0;

`ifdef KAMACORE_SUBWORD_LOAD_EN
    localparam logic [31:0] EXP_BYTE_S = 32'hFFFF_FFF0;
    localparam logic [31:0] EXP_HALF_U = 32'h0000_8001;
    localparam logic [31:0] EXP_HALF_S = 32'hFFFF_8001;
`else
    localparam logic [31:0] EXP_BYTE_S = 32'h00F0_0000;
    localparam logic [31:0] EXP_HALF_U = 32'h8001_7FFF;
    localparam logic [31:0] EXP_HALF_S = 32'h8001_7FFF;
`endif

    kamacore_writeback #(.LOAD_TIMEOUT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .ex_rd            (ex_rd),
        .ex_data          (ex_data),
        .ex_is_load       (ex_is_load),
        .ex_load_size     (ex_load_size),
        .ex_load_signed   (ex_load_signed),
        .ex_byte_off      (ex_byte_off),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .destination_we   (destination_we),
        .destination_a    (destination_a),
        .destination_data (destination_data),
        .busy             (busy),
        .load_timeout     (load_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_load(input logic [4:0] rd, input load_size_t sz,
                              input logic sgn, input logic [1:0] off,
                              input logic [31:0] rdata, input int waits);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd;
        ex_load_size = sz; ex_load_signed = sgn; ex_byte_off = off;
        tick();
        ex_valid = 1'b0; ex_is_load = 1'b0;
        repeat (waits) tick();
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; ex_valid = 1'b0; ex_rd = '0; ex_data = '0;
        ex_is_load = 1'b0; ex_load_size = LOAD_WORD;
        ex_load_signed = 1'b0; ex_byte_off = 2'd0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        total++;
        if ({destination_we, destination_a, destination_data} !== 38'd0) begin
            bad++;
            $display("FAIL reset_dest got we=%b a=%0d d=%h want 0", destination_we, destination_a, destination_data);
        end
        total++;
        if ({busy, load_timeout, ex_ready} !== 3'b001) begin
            bad++;
            $display("FAIL reset_ctl got busy/to/rdy=%b want 001", {busy, load_timeout, ex_ready});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'h1234_5678;
        tick();
        ex_valid = 1'b0;
        total++;
        if ({destination_we, destination_a, destination_data} !== {1'b1, 5'd5, 32'h1234_5678}) begin
            bad++;
            $display("FAIL alu_write got we=%b a=%0d d=%h want 1/5/12345678", destination_we, destination_a, destination_data);
        end
        tick();
        total++;
        if ({destination_we, destination_a, destination_data} !== {1'b0, 5'd5, 32'h1234_5678}) begin
            bad++;
            $display("FAIL alu_hold got we=%b a=%0d d=%h want 0/5/12345678", destination_we, destination_a, destination_data);
        end
    endtask

    task automatic test_rd_zero();
        ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'hDEAD_BEEF;
        tick();
        ex_valid = 1'b0;
        total++;
        if ({destination_we, destination_a, destination_data} !== {1'b0, 5'd0, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL rd0 got we=%b a=%0d d=%h want 0/0/deadbeef", destination_we, destination_a, destination_data);
        end
    endtask

    task automatic test_load();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7;
        ex_load_size = LOAD_BYTE; ex_load_signed = 1'b1; ex_byte_off = 2'd2;
        tick();
        ex_valid = 1'b0; ex_is_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({ex_ready, busy, destination_we} !== 3'b010) begin
                bad++;
                $display("FAIL load_wait%0d got rdy/busy/we=%b want 010", i, {ex_ready, busy, destination_we});
            end
            if (i < 2) tick();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h00F0_0000;
        tick();
        mem_rvalid = 1'b0;
        total++;
        if ({destination_we, destination_a, destination_data} !== {1'b1, 5'd7, EXP_BYTE_S}) begin
            bad++;
            $display("FAIL load_byte got we=%b a=%0d d=%h want 1/7/%h", destination_we, destination_a, destination_data, EXP_BYTE_S);
        end
        total++;
        if ({ex_ready, busy} !== 2'b10) begin
            bad++;
            $display("FAIL load_done got rdy/busy=%b want 10", {ex_ready, busy});
        end
        tick();
        total++;
        if (destination_we !== 1'b0) begin
            bad++;
            $display("FAIL load_once got we=%b want 0", destination_we);
        end
    endtask

    task automatic test_subword();
        issue_load(5'd10, LOAD_HALF, 1'b0, 2'd2, 32'h8001_7FFF, 1);
        total++;
        if ({destination_we, destination_a, destination_data} !== {1'b1, 5'd10, EXP_HALF_U}) begin
            bad++;
            $display("FAIL half_u got we=%b a=%0d d=%h want 1/10/%h", destination_we, destination_a, destination_data, EXP_HALF_U);
        end
        issue_load(5'd11, LOAD_HALF, 1'b1, 2'd2, 32'h8001_7FFF, 0);
        total++;
        if ({destination_we, destination_a, destination_data} !== {1'b1, 5'd11, EXP_HALF_S}) begin
            bad++;
            $display("FAIL half_s got we=%b a=%0d d=%h want 1/11/%h", destination_we, destination_a, destination_data, EXP_HALF_S);
        end
        tick();
    endtask

    task automatic test_timeout();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9;
        ex_load_size = LOAD_WORD;
        tick();
        ex_valid = 1'b0; ex_is_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({busy, load_timeout} !== 2'b10) begin
                bad++;
                $display("FAIL to_wait%0d got busy/to=%b want 10", i, {busy, load_timeout});
            end
            tick();
        end
        total++;
        if ({load_timeout, destination_we, ex_ready, busy} !== 4'b1010) begin
            bad++;
            $display("FAIL to_pulse got to/we/rdy/busy=%b want 1010", {load_timeout, destination_we, ex_ready, busy});
        end
        tick();
        total++;
        if ({load_timeout, destination_we} !== 2'b00) begin
            bad++;
            $display("FAIL to_end got to/we=%b want 00", {load_timeout, destination_we});
        end
    endtask

    task automatic test_timeout_priority();
        issue_load(5'd12, LOAD_WORD, 1'b0, 2'd0, 32'hCAFE_0001, 3);
        total++;
        if ({load_timeout, destination_we, destination_a, destination_data} !== {1'b0, 1'b1, 5'd12, 32'hCAFE_0001}) begin
            bad++;
            $display("FAIL to_prio got to=%b we=%b a=%0d d=%h want 0/1/12/cafe0001", load_timeout, destination_we, destination_a, destination_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_load();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
        tick();
        ex_valid = 1'b0; ex_is_load = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        total++;
        if ({busy, ex_ready, destination_we, destination_a, destination_data} !== {2'b01, 38'd0}) begin
            bad++;
            $display("FAIL rst_async got busy=%b rdy=%b we=%b a=%0d d=%h", busy, ex_ready, destination_we, destination_a, destination_data);
        end
        tick();
        rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_rvalid = 1'b0;
        total++;
        if ({busy, destination_we, destination_a, destination_data} !== 39'd0) begin
            bad++;
            $display("FAIL rst_discard got busy=%b we=%b a=%0d d=%h want 0", busy, destination_we, destination_a, destination_data);
        end
    endtask

    task automatic test_back_to_back();
        int nwr;
        nwr = 0;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 1; i <= 3; i++) begin
            ex_valid = 1'b1; ex_rd = 5'(i); ex_data = 32'h11 * i;
            tick();
            if (destination_we) nwr++;
            total++;
            if ({destination_we, destination_a, destination_data} !== {1'b1, 5'(i), 32'h11 * i}) begin
                bad++;
                $display("FAIL b2b_%0d got we=%b a=%0d d=%h", i, destination_we, destination_a, destination_data);
            end
        end
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (destination_we) nwr++;
        end
        mem_rvalid = 1'b0;
        total++;
        if (nwr !== 3) begin
            bad++;
            $display("FAIL b2b_count got %0d want 3", nwr);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_rd_zero();
        test_load();
        test_subword();
        test_timeout();
        test_timeout_priority();
        test_reset_mid_load();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
